// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// FSM state encoding, operation select codes and the default operand width.
package mult_div_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MRUN = 3'd1,
      DRUN = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/mult_div_if.sv
// Request/response bundle between the control unit (master) and the
// multiply/divide unit (slave).
interface mult_div_if #(parameter int WIDTH = 32);

   logic             start;
   logic             op_div;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div0;

   modport master (
      output start, op_div, a_in, b_in,
      input  hi, lo, busy, done, div0
   );

   modport slave (
      input  start, op_div, a_in, b_in,
      output hi, lo, busy, done, div0
   );

endinterface

// File: rtl/mult_div_unit_div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem,quot}
// left, trial-subtract the divisor, keep the difference when it is non-negative.
module div_restore_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quot,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quot
);

   logic [WIDTH:0]   w_shifted;
   logic [WIDTH:0]   w_trial;

   // Extra top bit keeps the borrow so the sign of the trial is visible.
   assign w_shifted = {i_rem, i_quot[WIDTH-1]};
   assign w_trial   = w_shifted - {1'b0, i_divisor};

   always_comb begin
      o_quot = {i_quot[WIDTH-2:0], 1'b0};
      o_rem  = w_shifted[WIDTH-1:0];
      if (!w_trial[WIDTH]) begin
         o_quot = {i_quot[WIDTH-2:0], 1'b1};
         o_rem  = w_trial[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (radix-2 Booth) / DIV (sign-magnitude restoring) unit
// holding the HI/LO registers read by MFHI/MFLO.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input  logic        clk,
   input  logic        reset_in,
   mult_div_if.slave   bus
);

   state_t             r_state;
   logic [CNT_W-1:0]   r_count;
   logic               r_op;
   logic               r_sign_a;
   logic               r_sign_b;
   logic [2*WIDTH:0]   r_prod;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quot;
   logic [WIDTH-1:0]   r_divisor;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic               r_div0;

   logic [WIDTH:0]     w_upper_ext;
   logic [WIDTH:0]     w_mcand_ext;
   logic [WIDTH:0]     w_booth_sum;
   logic [2*WIDTH:0]   w_prod_next;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH-1:0]   w_rem_next;
   logic [WIDTH-1:0]   w_quot_next;
   logic               w_last;

   // Upper half is widened by one bit so -2^(W-1) as multiplicand cannot
   // overflow the accumulator before the arithmetic shift.
   assign w_upper_ext = {r_prod[2*WIDTH], r_prod[2*WIDTH:WIDTH+1]};
   assign w_mcand_ext = {r_mcand[WIDTH-1], r_mcand};

   always_comb begin
      w_booth_sum = w_upper_ext;
      case (r_prod[1:0])
         2'b01:   w_booth_sum = w_upper_ext + w_mcand_ext;
         2'b10:   w_booth_sum = w_upper_ext - w_mcand_ext;
         default: w_booth_sum = w_upper_ext;
      endcase
   end

   assign w_prod_next = {w_booth_sum, r_prod[WIDTH:1]};
   assign w_abs_a     = bus.a_in[WIDTH-1] ? (~bus.a_in + 1'b1) : bus.a_in;
   assign w_abs_b     = bus.b_in[WIDTH-1] ? (~bus.b_in + 1'b1) : bus.b_in;
   assign w_last      = (r_count == CNT_W'(WIDTH-1));

   div_restore_step #(.WIDTH(WIDTH)) u_div_step (
      .i_rem     (r_rem),
      .i_quot    (r_quot),
      .i_divisor (r_divisor),
      .o_rem     (w_rem_next),
      .o_quot    (w_quot_next)
   );

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_op      <= OP_MULT;
         r_sign_a  <= 1'b0;
         r_sign_b  <= 1'b0;
         r_prod    <= '0;
         r_mcand   <= '0;
         r_rem     <= '0;
         r_quot    <= '0;
         r_divisor <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_div0    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_div0 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_busy   <= 1'b1;
                  r_count  <= '0;
                  r_op     <= bus.op_div;
                  r_sign_a <= bus.a_in[WIDTH-1];
                  r_sign_b <= bus.b_in[WIDTH-1];
                  if (bus.op_div == OP_MULT) begin
                     r_mcand <= bus.a_in;
                     r_prod  <= {{WIDTH{1'b0}}, bus.b_in, 1'b0};
                     r_state <= MRUN;
                  end else if (bus.b_in == '0) begin
                     r_done  <= 1'b1;
                     r_div0  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_rem     <= '0;
                     r_quot    <= w_abs_a;
                     r_divisor <= w_abs_b;
                     r_state   <= DRUN;
                  end
               end
            end
            MRUN: begin
               r_prod  <= w_prod_next;
               r_count <= r_count + 1'b1;
               if (w_last) r_state <= FIX;
            end
            DRUN: begin
               r_rem   <= w_rem_next;
               r_quot  <= w_quot_next;
               r_count <= r_count + 1'b1;
               if (w_last) r_state <= FIX;
            end
            FIX: begin
               if (r_op == OP_DIV) begin
                  r_lo <= (r_sign_a ^ r_sign_b) ? (~r_quot + 1'b1) : r_quot;
                  r_hi <= r_sign_a ? (~r_rem + 1'b1) : r_rem;
               end else begin
                  r_hi <= r_prod[2*WIDTH:WIDTH+1];
                  r_lo <= r_prod[WIDTH:1];
               end
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.div0 = r_div0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// MULT/DIV operations against a plain-arithmetic reference model.
module tb_mult_div_unit;

   localparam int W = 32;

   logic clk;
   logic reset_in;
   int   checks;
   int   errors;

   logic [W-1:0] cur_hi;
   logic [W-1:0] cur_lo;

   mult_div_if #(.WIDTH(W)) bus ();

   mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk      (clk),
      .reset_in (reset_in),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction: drive start for one edge, then watch every cycle until
   // two cycles past the expected done pulse.
   task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke);
      logic signed [63:0] sa, sb, res, rem;
      logic [W-1:0]       new_hi, new_lo;
      int                 exp_n;
      bit                 exp_div0;
      sa = {{32{a[W-1]}}, a};
      sb = {{32{b[W-1]}}, b};
      exp_div0 = 1'b0;
      exp_n    = 33;
      if (op == 1'b0) begin
         res    = sa * sb;
         new_hi = res[63:32];
         new_lo = res[31:0];
      end else if (b == '0) begin
         exp_div0 = 1'b1;
         exp_n    = 0;
         new_hi   = cur_hi;
         new_lo   = cur_lo;
      end else begin
         res    = sa / sb;
         rem    = sa % sb;
         new_lo = res[31:0];
         new_hi = rem[31:0];
      end

      @(negedge clk);
      bus.start  = 1'b1;
      bus.op_div = op;
      bus.a_in   = a;
      bus.b_in   = b;
      @(posedge clk);
      for (int n = 0; n <= exp_n + 2; n++) begin
         @(negedge clk);
         if (n == 0) bus.start = 1'b0;
         if (poke && n == 5) begin
            bus.start = 1'b1;
            bus.a_in  = $urandom;
            bus.b_in  = $urandom;
         end
         if (poke && n == 6) bus.start = 1'b0;
         check("done",  {63'd0, bus.done}, {63'd0, (n == exp_n)});
         check("div0",  {63'd0, bus.div0}, {63'd0, (exp_div0 && n == exp_n)});
         check("busy",  {63'd0, bus.busy}, {63'd0, (n <= exp_n)});
         check("hi",    {32'd0, bus.hi}, {32'd0, (n >= exp_n) ? new_hi : cur_hi});
         check("lo",    {32'd0, bus.lo}, {32'd0, (n >= exp_n) ? new_lo : cur_lo});
      end
      $display("op=%s a=%h b=%h -> hi=%h lo=%h div0=%0b (expected hi=%h lo=%h)",
               op ? "DIV " : "MULT", a, b, bus.hi, bus.lo, exp_div0, new_hi, new_lo);
      cur_hi = new_hi;
      cur_lo = new_lo;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      cur_hi     = '0;
      cur_lo     = '0;
      bus.start  = 1'b0;
      bus.op_div = 1'b0;
      bus.a_in   = '0;
      bus.b_in   = '0;
      reset_in   = 1'b0;
      #2;
      check("rst_hi",   {32'd0, bus.hi}, 64'd0);
      check("rst_lo",   {32'd0, bus.lo}, 64'd0);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      check("rst_div0", {63'd0, bus.div0}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset_in = 1'b1;

      run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(1'b0, 32'h48D1_59E0, 32'h4000_0000, 1'b0);
      check("preload_hi", {32'd0, bus.hi}, 64'h0000_0000_1234_5678);
      run_op(1'b1, 32'h0000_1234, 32'h0000_0000, 1'b0);
      run_op(1'b0, 32'h0000_0123, 32'hFFFF_0042, 1'b1);

      for (int i = 0; i < 12; i++) begin
         logic          rop;
         logic [W-1:0]  ra, rb;
         rop = 1'($urandom_range(0, 1));
         ra  = $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 9);
         run_op(rop, ra, rb, (rop == 1'b0) && ($urandom_range(0, 1) == 1));
      end

      run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op_div = 1'b1;
      bus.a_in   = 32'h0ABC_DEF0;
      bus.b_in   = 32'h0000_0013;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_busy", {63'd0, bus.busy}, 64'd1);
      #2 reset_in = 1'b0;
      #1;
      check("arst_hi",   {32'd0, bus.hi}, 64'd0);
      check("arst_lo",   {32'd0, bus.lo}, 64'd0);
      check("arst_busy", {63'd0, bus.busy}, 64'd0);
      check("arst_done", {63'd0, bus.done}, 64'd0);
      $display("async reset mid-DRUN: hi=%h lo=%h busy=%0b", bus.hi, bus.lo, bus.busy);
      cur_hi = '0;
      cur_lo = '0;
      @(negedge clk);
      reset_in = 1'b1;
      run_op(1'b0, 32'd3, 32'd4, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
